// File: rtl/onchip_mem_port_arbiter.sv
// onchip_mem_port_arbiter
// Shares one port of the on-chip memory between two Avalon-MM style requesters.
// Round-robin arbitration with a bounded burst lock, out-of-range address
// protection and a sticky error flag.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   rq{0,1}_address       word address from requester
//   rq{0,1}_byteenable    byte enables from requester
//   rq{0,1}_write/_read   transfer requests
//   rq{0,1}_writedata     write data from requester
//   rq{0,1}_waitrequest   request not accepted this cycle
//   rq{0,1}_readdata      read data (valid with readdatavalid)
//   rq{0,1}_readdatavalid read response strobe, one cycle after acceptance
//   mem_*                 memory port (1-cycle read latency on mem_readdata)
//   err_clear             clears err_oor
//   err_oor               sticky out-of-range / read+write collision flag
module onchip_mem_port_arbiter #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BE_W      = 4,
  parameter int unsigned DEPTH     = 60000,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] rq0_address,
  input  logic [BE_W-1:0]   rq0_byteenable,
  input  logic              rq0_write,
  input  logic [DATA_W-1:0] rq0_writedata,
  input  logic              rq0_read,
  output logic              rq0_waitrequest,
  output logic [DATA_W-1:0] rq0_readdata,
  output logic              rq0_readdatavalid,

  input  logic [ADDR_W-1:0] rq1_address,
  input  logic [BE_W-1:0]   rq1_byteenable,
  input  logic              rq1_write,
  input  logic [DATA_W-1:0] rq1_writedata,
  input  logic              rq1_read,
  output logic              rq1_waitrequest,
  output logic [DATA_W-1:0] rq1_readdata,
  output logic              rq1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,

  input  logic              err_clear,
  output logic              err_oor
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0]   MaxCnt = CntW'(MAX_BURST);
  // One extra bit so DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0]   DepthV = (ADDR_W + 1)'(DEPTH);

  // Registered state. r_last_owner: 0 = requester 0, 1 = requester 1.
  logic            r_last_owner, w_last_owner_d;
  logic [CntW-1:0] r_beat_cnt, w_beat_cnt_d;
  logic            r_rvalid0, w_rvalid0_d;
  logic            r_rvalid1, w_rvalid1_d;
  logic            r_rzero, w_rzero_d;
  logic            r_err, w_err_d;

  logic w_req0, w_req1;
  logic w_gnt0, w_gnt1;
  logic w_any, w_sel;
  logic w_keep;
  logic [ADDR_W-1:0] w_addr;
  logic              w_wr, w_rd;
  logic              w_in_range;
  logic              w_acc_rd;
  logic              w_err_evt;

  assign w_req0 = rq0_read | rq0_write;
  assign w_req1 = rq1_read | rq1_write;

  // beat_cnt == 0 means nobody owned the previous cycle (reset or idle), so
  // a tie then goes to the requester that is not last_owner.
  assign w_keep = (r_beat_cnt != '0) && (r_beat_cnt < MaxCnt);

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_req0 && !w_req1) begin
      w_gnt0 = 1'b1;
    end else if (!w_req0 && w_req1) begin
      w_gnt1 = 1'b1;
    end else if (w_req0 && w_req1) begin
      if (w_keep) begin
        w_gnt0 = ~r_last_owner;
        w_gnt1 = r_last_owner;
      end else begin
        w_gnt0 = r_last_owner;
        w_gnt1 = ~r_last_owner;
      end
    end
  end

  assign w_any = w_gnt0 | w_gnt1;
  assign w_sel = w_gnt1;

  assign rq0_waitrequest = w_req0 & ~w_gnt0;
  assign rq1_waitrequest = w_req1 & ~w_gnt1;

  // With no grant the mux defaults to requester 0.
  assign w_addr         = w_sel ? rq1_address    : rq0_address;
  assign w_wr           = w_sel ? rq1_write      : rq0_write;
  assign w_rd           = w_sel ? rq1_read       : rq0_read;
  assign mem_byteenable = w_sel ? rq1_byteenable : rq0_byteenable;
  assign mem_writedata  = w_sel ? rq1_writedata  : rq0_writedata;
  assign mem_address    = w_addr;

  assign w_in_range     = {1'b0, w_addr} < DepthV;
  assign mem_chipselect = w_any & w_in_range;
  assign mem_write      = w_any & w_wr & w_in_range;

  // A read that collides with a write on the same requester is dropped.
  assign w_acc_rd  = w_any & w_rd & ~w_wr;
  assign w_err_evt = w_any & (~w_in_range | (w_rd & w_wr));

  always_comb begin
    w_last_owner_d = r_last_owner;
    w_beat_cnt_d   = '0;
    if (w_any) begin
      w_last_owner_d = w_sel;
      if (w_sel == r_last_owner) begin
        w_beat_cnt_d = (r_beat_cnt < MaxCnt) ? r_beat_cnt + 1'b1 : r_beat_cnt;
      end else begin
        w_beat_cnt_d = CntW'(1);
      end
    end
    w_rvalid0_d = w_acc_rd & ~w_sel;
    w_rvalid1_d = w_acc_rd & w_sel;
    w_rzero_d   = ~w_in_range;
    // Set beats clear when both happen in the same cycle.
    if (w_err_evt) begin
      w_err_d = 1'b1;
    end else if (err_clear) begin
      w_err_d = 1'b0;
    end else begin
      w_err_d = r_err;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_owner <= 1'b1;
      r_beat_cnt   <= '0;
      r_rvalid0    <= 1'b0;
      r_rvalid1    <= 1'b0;
      r_rzero      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_last_owner <= w_last_owner_d;
      r_beat_cnt   <= w_beat_cnt_d;
      r_rvalid0    <= w_rvalid0_d;
      r_rvalid1    <= w_rvalid1_d;
      r_rzero      <= w_rzero_d;
      r_err        <= w_err_d;
    end
  end

  // Only one read is accepted per cycle, so the memory data is shared.
  assign rq0_readdata      = r_rzero ? '0 : mem_readdata;
  assign rq1_readdata      = r_rzero ? '0 : mem_readdata;
  assign rq0_readdatavalid = r_rvalid0;
  assign rq1_readdatavalid = r_rvalid1;
  assign err_oor           = r_err;

endmodule

// File: tb/tb_onchip_mem_port_arbiter.sv
// Directed testbench for onchip_mem_port_arbiter with a small memory model.
module tb_onchip_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] rq0_address, rq1_address;
  logic [3:0]  rq0_byteenable, rq1_byteenable;
  logic        rq0_write, rq1_write, rq0_read, rq1_read;
  logic [31:0] rq0_writedata, rq1_writedata;
  logic        rq0_waitrequest, rq1_waitrequest;
  logic [31:0] rq0_readdata, rq1_readdata;
  logic        rq0_readdatavalid, rq1_readdatavalid;
  logic [15:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write;
  logic [31:0] mem_writedata, mem_readdata;
  logic        err_clear, err_oor;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  onchip_mem_port_arbiter dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .rq0_address       (rq0_address),
    .rq0_byteenable    (rq0_byteenable),
    .rq0_write         (rq0_write),
    .rq0_writedata     (rq0_writedata),
    .rq0_read          (rq0_read),
    .rq0_waitrequest   (rq0_waitrequest),
    .rq0_readdata      (rq0_readdata),
    .rq0_readdatavalid (rq0_readdatavalid),
    .rq1_address       (rq1_address),
    .rq1_byteenable    (rq1_byteenable),
    .rq1_write         (rq1_write),
    .rq1_writedata     (rq1_writedata),
    .rq1_read          (rq1_read),
    .rq1_waitrequest   (rq1_waitrequest),
    .rq1_readdata      (rq1_readdata),
    .rq1_readdatavalid (rq1_readdatavalid),
    .mem_address       (mem_address),
    .mem_byteenable    (mem_byteenable),
    .mem_chipselect    (mem_chipselect),
    .mem_write         (mem_write),
    .mem_writedata     (mem_writedata),
    .mem_readdata      (mem_readdata),
    .err_clear         (err_clear),
    .err_oor           (err_oor)
  );

  // Memory model: byte-enabled write, 1-cycle registered read.
  logic [31:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end
      mem_readdata <= mem[mem_address];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic idle_inputs();
    rq0_address = '0; rq0_byteenable = 4'hF; rq0_write = 1'b0; rq0_read = 1'b0;
    rq0_writedata = '0;
    rq1_address = '0; rq1_byteenable = 4'hF; rq1_write = 1'b0; rq1_read = 1'b0;
    rq1_writedata = '0;
    err_clear = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  int pat [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    mem_readdata = '0;
    @(negedge clk);
    @(negedge clk);

    // Reset state and tie resolution under reset
    check("rst_err", 32'(err_oor), 0);
    check("rst_rv0", 32'(rq0_readdatavalid), 0);
    check("rst_rv1", 32'(rq1_readdatavalid), 0);
    rq0_read = 1'b1; rq1_read = 1'b1;
    #1;
    check("rst_wait0", 32'(rq0_waitrequest), 0);
    check("rst_wait1", 32'(rq1_waitrequest), 1);
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;

    // Single writer then read-back by requester 1
    @(negedge clk);
    rq0_write = 1'b1; rq0_address = 16'h0010; rq0_writedata = 32'hDEADBEEF;
    #1;
    check("wr_wait0", 32'(rq0_waitrequest), 0);
    check("wr_cs", 32'(mem_chipselect), 1);
    check("wr_memwr", 32'(mem_write), 1);
    @(negedge clk);
    idle_inputs();
    rq1_read = 1'b1; rq1_address = 16'h0010;
    #1;
    check("rd_wait1", 32'(rq1_waitrequest), 0);
    check("rd_memwr", 32'(mem_write), 0);
    @(negedge clk);
    idle_inputs();
    check("rd_rv1", 32'(rq1_readdatavalid), 1);
    check("rd_data1", rq1_readdata, 32'hDEADBEEF);
    check("rd_rv0", 32'(rq0_readdatavalid), 0);

    // Partial byte-enable write
    rq0_write = 1'b1; rq0_address = 16'h0010; rq0_writedata = 32'h11223344;
    rq0_byteenable = 4'h3;
    @(negedge clk);
    idle_inputs();
    rq0_read = 1'b1; rq0_address = 16'h0010;
    @(negedge clk);
    idle_inputs();
    check("be_rv0", 32'(rq0_readdatavalid), 1);
    check("be_data0", rq0_readdata, 32'hDEAD3344);

    // Contention from reset: 0,0,0,0,1,1,1,1,0
    reset_pulse();
    rq0_read = 1'b1; rq0_address = 16'h0010;
    rq1_read = 1'b1; rq1_address = 16'h0020;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin
        check($sformatf("cont_rv0_%0d", i - 1), 32'(rq0_readdatavalid), 32'(pat[i-1] == 0));
        check($sformatf("cont_rv1_%0d", i - 1), 32'(rq1_readdatavalid), 32'(pat[i-1] == 1));
      end
      #1;
      check($sformatf("cont_wait0_%0d", i), 32'(rq0_waitrequest), 32'(pat[i] != 0));
      check($sformatf("cont_wait1_%0d", i), 32'(rq1_waitrequest), 32'(pat[i] != 1));
      @(negedge clk);
    end
    check("cont_rv0_8", 32'(rq0_readdatavalid), 1);
    check("cont_data0", rq0_readdata, 32'hDEAD3344);
    idle_inputs();

    // Tie after an idle cycle following reset: rq0 first, burst restarts at 1
    reset_pulse();
    @(negedge clk);
    rq0_read = 1'b1; rq1_read = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("tie_wait0_%0d", i), 32'(rq0_waitrequest), 32'(pat[i] != 0));
      @(negedge clk);
    end
    idle_inputs();

    // Boundary and out-of-range addresses
    @(negedge clk);
    rq1_write = 1'b1; rq1_address = 16'd59999; rq1_writedata = 32'h5A5A5A5A;
    #1;
    check("b_cs_wr", 32'(mem_chipselect), 1);
    @(negedge clk);
    rq1_write = 1'b0; rq1_read = 1'b1;
    #1;
    check("b_cs_rd", 32'(mem_chipselect), 1);
    @(negedge clk);
    check("b_rv1", 32'(rq1_readdatavalid), 1);
    check("b_data1", rq1_readdata, 32'h5A5A5A5A);
    check("b_err", 32'(err_oor), 0);
    rq1_read = 1'b0; rq1_write = 1'b1; rq1_address = 16'd60000;
    #1;
    check("oor_cs_wr", 32'(mem_chipselect), 0);
    check("oor_memwr", 32'(mem_write), 0);
    check("oor_wait1", 32'(rq1_waitrequest), 0);
    @(negedge clk);
    check("oor_err_wr", 32'(err_oor), 1);
    rq1_write = 1'b0; rq1_read = 1'b1; rq1_address = 16'd65535;
    #1;
    check("oor_cs_rd", 32'(mem_chipselect), 0);
    @(negedge clk);
    check("oor_rv1", 32'(rq1_readdatavalid), 1);
    check("oor_data1", rq1_readdata, 32'h0);
    check("oor_err_rd", 32'(err_oor), 1);
    idle_inputs();
    err_clear = 1'b1;
    @(negedge clk);
    check("clr_err", 32'(err_oor), 0);
    rq0_read = 1'b1; rq0_address = 16'd60000;  // set with clear held
    @(negedge clk);
    check("set_prio", 32'(err_oor), 1);
    idle_inputs();
    err_clear = 1'b1;
    @(negedge clk);
    check("clr_err2", 32'(err_oor), 0);
    idle_inputs();

    // Read+write collision on one requester
    rq0_read = 1'b1; rq0_write = 1'b1; rq0_address = 16'd5; rq0_writedata = 32'hCAFEF00D;
    #1;
    check("col_memwr", 32'(mem_write), 1);
    check("col_cs", 32'(mem_chipselect), 1);
    @(negedge clk);
    check("col_rv0", 32'(rq0_readdatavalid), 0);
    check("col_err", 32'(err_oor), 1);
    idle_inputs();
    err_clear = 1'b1;
    @(negedge clk);
    idle_inputs();
    rq0_read = 1'b1; rq0_address = 16'd5;
    @(negedge clk);
    idle_inputs();
    check("col_rb_rv0", 32'(rq0_readdatavalid), 1);
    check("col_rb_data", rq0_readdata, 32'hCAFEF00D);
    check("col_rb_err", 32'(err_oor), 0);

    // Reset asserted while a read response is pending
    rq0_read = 1'b1; rq0_address = 16'd5;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rv0", 32'(rq0_readdatavalid), 0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rv0", 32'(rq0_readdatavalid), 0);
    rq0_read = 1'b1; rq1_read = 1'b1;
    #1;
    check("post_wait0", 32'(rq0_waitrequest), 0);
    check("post_wait1", 32'(rq1_waitrequest), 1);
    @(negedge clk);
    check("post_rv0b", 32'(rq0_readdatavalid), 1);
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
